// File: rtl/mem_burst_slave.sv
// Main-bus memory slave: decodes a page-matched address phase, then runs a
// fixed-length read or write burst (linear or block-wrapping) against one memory.
module mem_burst_slave #(
    parameter int                BUS_W     = 16,
    parameter int                PAGE_W    = 4,
    parameter int                OFFS_W    = 12,
    parameter logic [PAGE_W-1:0] PAGE      = 4'h2,
    parameter int                BURST_LEN = 4,
    parameter int                WRAP_MODE = 0,
    parameter int                RD_LAT    = 0
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              AddrValid,
    input  logic              rw,
    input  logic [BUS_W-1:0]  bus_in,
    output logic [BUS_W-1:0]  bus_out,
    output logic              bus_oe,
    output logic              busy,
    output logic [OFFS_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [BUS_W-1:0]  mem_wdata,
    input  logic [BUS_W-1:0]  mem_rdata
);

    localparam int                CNT_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(BURST_LEN - 1);
    localparam logic [OFFS_W-1:0] LOW_MASK = OFFS_W'(BURST_LEN - 1);

    typedef enum logic [1:0] {IDLE, RD_BEAT, RD_DRAIN, WR_BEAT} state_t;

    state_t            state;
    logic [CNT_W-1:0]  beat;
    logic [OFFS_W-1:0] base;

    logic              page_hit;
    logic [OFFS_W-1:0] offs;

    assign page_hit = (bus_in[BUS_W-1 -: PAGE_W] == PAGE);
    assign offs     = bus_in[OFFS_W-1:0];

    // Wrap mode keeps the bits above the burst block fixed and lets only the
    // low log2(BURST_LEN) bits roll over; BURST_LEN==1 gives a zero mask.
    function automatic logic [OFFS_W-1:0] beat_addr(input logic [OFFS_W-1:0] b,
                                                    input logic [CNT_W-1:0]  i);
        logic [OFFS_W-1:0] lin;
        lin = b + OFFS_W'(i);
        if (WRAP_MODE == 1)
            return (b & ~LOW_MASK) | (lin & LOW_MASK);
        else
            return lin;
    endfunction

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            beat      <= '0;
            base      <= '0;
            mem_addr  <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            bus_oe    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (AddrValid && page_hit) begin
                        base     <= offs;
                        beat     <= '0;
                        mem_addr <= offs;
                        if (rw) begin
                            state     <= RD_BEAT;
                            mem_rd_en <= 1'b1;
                            bus_oe    <= (RD_LAT == 0);
                        end else begin
                            state     <= WR_BEAT;
                            mem_wr_en <= 1'b1;
                        end
                    end
                end
                RD_BEAT: begin
                    if (beat == LAST) begin
                        beat      <= '0;
                        mem_rd_en <= 1'b0;
                        mem_addr  <= '0;
                        // Registered memory needs one more cycle to present the last word.
                        if (RD_LAT == 1) begin
                            state  <= RD_DRAIN;
                            bus_oe <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            bus_oe <= 1'b0;
                        end
                    end else begin
                        beat     <= beat + 1'b1;
                        mem_addr <= beat_addr(base, beat + 1'b1);
                        bus_oe   <= 1'b1;
                    end
                end
                RD_DRAIN: begin
                    bus_oe <= 1'b0;
                    state  <= IDLE;
                end
                WR_BEAT: begin
                    if (beat == LAST) begin
                        beat      <= '0;
                        mem_wr_en <= 1'b0;
                        mem_addr  <= '0;
                        state     <= IDLE;
                    end else begin
                        beat     <= beat + 1'b1;
                        mem_addr <= beat_addr(base, beat + 1'b1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign bus_out   = bus_oe ? mem_rdata : '0;
    assign mem_wdata = mem_wr_en ? bus_in : '0;

endmodule

// File: tb/tb_mem_burst_slave.sv
// Bench for mem_burst_slave: three instances (defaults, block wrap, RD_LAT=1 x8)
// checked every cycle against a schedule-based burst model plus literal spot checks.
module tb_mem_burst_slave;

    localparam int MAXC = 1024;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [2:0]  av = '0;
    logic        rw = 1'b0;
    logic [15:0] bus_in = '0;
    int          cyc = 0;

    logic [15:0] bus_out   [3];
    logic        oe        [3];
    logic        busy      [3];
    logic [11:0] mem_addr  [3];
    logic        rd_en     [3];
    logic        wr_en     [3];
    logic [15:0] mem_wdata [3];
    logic [15:0] rdata0, rdata1, rdata2;

    logic [15:0] dmem    [3][4096];
    logic [15:0] ref_mem [3][4096];

    bit exp_busy [3][MAXC];
    bit exp_rd   [3][MAXC];
    bit exp_wr   [3][MAXC];
    bit exp_oe   [3][MAXC];
    int exp_addr [3][MAXC];
    int exp_raddr[3][MAXC];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_burst_slave u0 (
        .clk(clk), .resetN(resetN), .AddrValid(av[0]), .rw(rw), .bus_in(bus_in),
        .bus_out(bus_out[0]), .bus_oe(oe[0]), .busy(busy[0]), .mem_addr(mem_addr[0]),
        .mem_rd_en(rd_en[0]), .mem_wr_en(wr_en[0]), .mem_wdata(mem_wdata[0]), .mem_rdata(rdata0));

    mem_burst_slave #(.WRAP_MODE(1)) u1 (
        .clk(clk), .resetN(resetN), .AddrValid(av[1]), .rw(rw), .bus_in(bus_in),
        .bus_out(bus_out[1]), .bus_oe(oe[1]), .busy(busy[1]), .mem_addr(mem_addr[1]),
        .mem_rd_en(rd_en[1]), .mem_wr_en(wr_en[1]), .mem_wdata(mem_wdata[1]), .mem_rdata(rdata1));

    mem_burst_slave #(.BURST_LEN(8), .RD_LAT(1)) u2 (
        .clk(clk), .resetN(resetN), .AddrValid(av[2]), .rw(rw), .bus_in(bus_in),
        .bus_out(bus_out[2]), .bus_oe(oe[2]), .busy(busy[2]), .mem_addr(mem_addr[2]),
        .mem_rd_en(rd_en[2]), .mem_wr_en(wr_en[2]), .mem_wdata(mem_wdata[2]), .mem_rdata(rdata2));

    // Memory arrays seen by the DUTs: 0/1 combinational read, 2 registered read.
    initial begin
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 4096; a++)
                dmem[k][a] <= 16'hA000 | 16'(a);
    end

    assign rdata0 = dmem[0][mem_addr[0]];
    assign rdata1 = dmem[1][mem_addr[1]];

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++)
            if (wr_en[k]) dmem[k][mem_addr[k]] <= mem_wdata[k];
        if (rd_en[2]) rdata2 <= dmem[2][mem_addr[2]];
    end

    function automatic int blen(input int k);
        return (k == 2) ? 8 : 4;
    endfunction

    function automatic int lat(input int k);
        return (k == 2) ? 1 : 0;
    endfunction

    function automatic int maddr(input int k, input int b, input int i);
        int n;
        n = blen(k);
        if (k == 1) return b - (b % n) + ((b % n) + i) % n;
        return (b + i) % 4096;
    endfunction

    task automatic chk(input string nm, input int k, input logic [15:0] act, input logic [15:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s[%0d] cycle %0d: got %h expected %h", nm, k, cyc, act, exp);
        end
    endtask

    // Model + per-cycle compare: an accepted request fills a schedule of
    // expected outputs for the following cycles.
    initial begin
        int c, b, t;
        logic [15:0] eo, ew;
        for (int k = 0; k < 3; k++)
            for (int a = 0; a < 4096; a++)
                ref_mem[k][a] = 16'hA000 | 16'(a);
        forever begin
            @(negedge clk);
            c = cyc;
            if (c >= MAXC - 20) continue;
            if (!resetN)
                for (int k = 0; k < 3; k++)
                    for (int cc = c; cc < MAXC; cc++) begin
                        exp_busy[k][cc] = 0; exp_rd[k][cc] = 0; exp_wr[k][cc] = 0;
                        exp_oe[k][cc] = 0; exp_addr[k][cc] = 0; exp_raddr[k][cc] = 0;
                    end
            for (int k = 0; k < 3; k++) begin
                eo = exp_oe[k][c] ? ref_mem[k][exp_raddr[k][c]] : 16'h0;
                ew = exp_wr[k][c] ? bus_in : 16'h0;
                chk("busy", k, 16'(busy[k]), 16'(exp_busy[k][c]));
                chk("mem_rd_en", k, 16'(rd_en[k]), 16'(exp_rd[k][c]));
                chk("mem_wr_en", k, 16'(wr_en[k]), 16'(exp_wr[k][c]));
                chk("mem_addr", k, 16'(mem_addr[k]), 16'(exp_addr[k][c]));
                chk("bus_oe", k, 16'(oe[k]), 16'(exp_oe[k][c]));
                chk("bus_out", k, bus_out[k], eo);
                chk("mem_wdata", k, mem_wdata[k], ew);
                if (exp_wr[k][c]) ref_mem[k][exp_addr[k][c]] = bus_in;
                if (resetN && av[k] && !exp_busy[k][c] && bus_in[15:12] == 4'h2) begin
                    b = int'(bus_in[11:0]);
                    for (int i = 0; i < blen(k); i++) begin
                        t = c + 1 + i;
                        exp_busy[k][t] = 1;
                        exp_addr[k][t] = maddr(k, b, i);
                        if (rw) begin
                            exp_rd[k][t] = 1;
                            exp_oe[k][t + lat(k)] = 1;
                            exp_raddr[k][t + lat(k)] = maddr(k, b, i);
                        end else begin
                            exp_wr[k][t] = 1;
                        end
                    end
                    if (rw && lat(k) == 1) exp_busy[k][c + blen(k) + 1] = 1;
                end
            end
        end
    end

    task automatic step(input logic [2:0] m, input logic r, input logic [15:0] d);
        @(posedge clk);
        #1;
        av = m; rw = r; bus_in = d;
    endtask

    task automatic idle(input int n);
        repeat (n) step(3'b000, 1'b0, 16'h0);
    endtask

    initial begin
        // reset state
        @(negedge clk);
        chk("rst_busy", 0, 16'(busy[0]), 16'h0);
        chk("rst_oe", 0, 16'(oe[0]), 16'h0);
        chk("rst_addr", 0, 16'(mem_addr[0]), 16'h0);
        @(posedge clk); #1 resetN = 1'b1;
        idle(2);

        // read, defaults
        step(3'b001, 1'b1, 16'h2010);
        idle(1);
        @(negedge clk);
        chk("rd_addr0", 0, 16'(mem_addr[0]), 16'h0010);
        chk("rd_data0", 0, bus_out[0], 16'hA010);
        chk("rd_oe0", 0, 16'(oe[0]), 16'h1);
        idle(2);
        @(negedge clk);
        chk("rd_data2", 0, bus_out[0], 16'hA012);
        idle(2);
        @(negedge clk);
        chk("rd_busy_end", 0, 16'(busy[0]), 16'h0);

        // write then read back
        step(3'b001, 1'b0, 16'h2100);
        step(3'b000, 1'b0, 16'h1111);
        step(3'b000, 1'b0, 16'h2222);
        @(negedge clk);
        chk("wr_addr1", 0, 16'(mem_addr[0]), 16'h0101);
        chk("wr_data1", 0, mem_wdata[0], 16'h2222);
        chk("wr_oe", 0, 16'(oe[0]), 16'h0);
        step(3'b000, 1'b0, 16'h3333);
        step(3'b000, 1'b0, 16'h4444);
        idle(1);
        step(3'b001, 1'b1, 16'h2100);
        idle(1);
        @(negedge clk);
        chk("rdback", 0, bus_out[0], 16'h1111);
        idle(4);

        // linear wrap at top of page
        step(3'b001, 1'b1, 16'h2FFE);
        idle(3);
        @(negedge clk);
        chk("lin_wrap", 0, 16'(mem_addr[0]), 16'h0000);
        idle(3);

        // block wrap
        step(3'b010, 1'b1, 16'h2006);
        idle(3);
        @(negedge clk);
        chk("blk_wrap2", 1, 16'(mem_addr[1]), 16'h0004);
        idle(1);
        @(negedge clk);
        chk("blk_wrap3", 1, 16'(mem_addr[1]), 16'h0005);
        idle(2);

        // registered read, 8 beats
        step(3'b100, 1'b1, 16'h2000);
        idle(1);
        @(negedge clk);
        chk("lat_rd_en", 2, 16'(rd_en[2]), 16'h1);
        chk("lat_oe_n1", 2, 16'(oe[2]), 16'h0);
        idle(1);
        @(negedge clk);
        chk("lat_data0", 2, bus_out[2], 16'hA000);
        idle(7);
        @(negedge clk);
        chk("lat_oe_n9", 2, 16'(oe[2]), 16'h1);
        chk("lat_data7", 2, bus_out[2], 16'hA007);
        chk("lat_rd_n9", 2, 16'(rd_en[2]), 16'h0);
        idle(1);
        @(negedge clk);
        chk("lat_busy", 2, 16'(busy[2]), 16'h0);

        // wrong page
        step(3'b001, 1'b1, 16'h3010);
        idle(1);
        @(negedge clk);
        chk("wp_busy", 0, 16'(busy[0]), 16'h0);
        chk("wp_rd", 0, 16'(rd_en[0]), 16'h0);
        idle(2);

        // request during a burst is dropped; back-to-back accept afterwards
        step(3'b001, 1'b1, 16'h2010);
        idle(1);
        step(3'b001, 1'b1, 16'h2020);
        idle(1);
        @(negedge clk);
        chk("ign_addr", 0, 16'(mem_addr[0]), 16'h0012);
        idle(1);
        step(3'b001, 1'b0, 16'h2030);
        step(3'b000, 1'b0, 16'h5555);
        @(negedge clk);
        chk("b2b_wr", 0, 16'(wr_en[0]), 16'h1);
        chk("b2b_addr", 0, 16'(mem_addr[0]), 16'h0030);
        step(3'b000, 1'b0, 16'h6666);
        step(3'b000, 1'b0, 16'h7777);
        step(3'b000, 1'b0, 16'h8888);
        idle(2);

        // reset mid write burst
        step(3'b001, 1'b0, 16'h2040);
        step(3'b000, 1'b0, 16'h7777);
        @(posedge clk); #1 resetN = 1'b0; bus_in = 16'h8888;
        @(negedge clk);
        chk("mid_rst_wr", 0, 16'(wr_en[0]), 16'h0);
        chk("mid_rst_busy", 0, 16'(busy[0]), 16'h0);
        chk("mid_rst_oe", 0, 16'(oe[0]), 16'h0);
        @(posedge clk); #1 resetN = 1'b1; bus_in = 16'h0;
        step(3'b001, 1'b0, 16'h2040);
        step(3'b000, 1'b0, 16'h9999);
        step(3'b000, 1'b0, 16'hAAAA);
        step(3'b000, 1'b0, 16'hBBBB);
        step(3'b000, 1'b0, 16'hCCCC);
        idle(1);
        step(3'b001, 1'b1, 16'h2040);
        idle(1);
        @(negedge clk);
        chk("post_rst_rd", 0, bus_out[0], 16'h9999);
        idle(5);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
